// File: rtl/fp_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_mul_seq_pkg
// Brief  : Shared widths, biases, NaN constants and state encodings.
// Rev    : 1.0  initial release
// ============================================================================
package fp_mul_seq_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int EXP_WIDTH       = 11;
    localparam int MANT_WIDTH      = 52;
    localparam int SIG_WIDTH       = MANT_WIDTH + 1;
    localparam int PROD_WIDTH      = 2 * SIG_WIDTH;
    localparam int EXPC_WIDTH      = EXP_WIDTH + 2;
    localparam int CNT_WIDTH       = 6;

    localparam int SGL_EXP_WIDTH   = 8;
    localparam int SGL_MANT_WIDTH  = 23;
    localparam int SGL_SIG_WIDTH   = SGL_MANT_WIDTH + 1;

    localparam logic signed [EXPC_WIDTH-1:0] C_BIAS_DBL = 13'sd1023;
    localparam logic signed [EXPC_WIDTH-1:0] C_BIAS_SGL = 13'sd127;
    localparam logic signed [EXPC_WIDTH-1:0] C_EMAX_DBL = 13'sd2047;
    localparam logic signed [EXPC_WIDTH-1:0] C_EMAX_SGL = 13'sd255;

    localparam logic [EXP_WIDTH-1:0]     C_EXP_ONES_DBL = 11'h7FF;
    localparam logic [SGL_EXP_WIDTH-1:0] C_EXP_ONES_SGL = 8'hFF;

    localparam logic [DATA_WIDTH-1:0] C_QNAN_DBL = 64'h7FF8_0000_0000_0000;
    localparam logic [DATA_WIDTH-1:0] C_QNAN_SGL = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [31:0]           C_BOX      = 32'hFFFF_FFFF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] K_NORMAL = 2'd0;
    localparam logic [1:0] K_NAN    = 2'd1;
    localparam logic [1:0] K_ZERO   = 2'd2;
    localparam logic [1:0] K_INF    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fp_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module : fp_mul_seq_if
// Brief  : Operand/result valid-ready bus of the sequential FP multiplier.
// Rev    : 1.0  initial release
// ============================================================================
interface fp_mul_seq_if;
    import fp_mul_seq_pkg::*;

    logic                  in_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] in_numA;
    logic [DATA_WIDTH-1:0] in_numB;
    logic                  in_fmt;
    logic                  out_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_result;

    modport master (
        output in_valid, in_numA, in_numB, in_fmt, in_ready,
        input  out_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_numA, in_numB, in_fmt, in_ready,
        output out_ready, out_valid, out_result
    );

endinterface
`default_nettype wire

// File: rtl/fp_mul_seq_mant.sv
`default_nettype none
// ============================================================================
// Module : fp_mul_seq_mant
// Brief  : Radix-2 shift-add significand multiplier, one multiplier bit/cycle.
// Rev    : 1.0  initial release
// ============================================================================
module fp_mul_seq_mant
    import fp_mul_seq_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic                  dbl_sel,
    input  wire logic [SIG_WIDTH-1:0]  mant_a,
    input  wire logic [SIG_WIDTH-1:0]  mant_b,
    output logic      [PROD_WIDTH-1:0] product,
    output logic                       done
);

    logic [PROD_WIDTH-1:0] r_mcand;
    logic [SIG_WIDTH-1:0]  r_mplier;
    logic [PROD_WIDTH-1:0] r_prod;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_busy;
    logic                  r_dbl;
    logic [CNT_WIDTH-1:0]  w_last;

    assign w_last  = r_dbl ? CNT_WIDTH'(SIG_WIDTH - 1) : CNT_WIDTH'(SGL_SIG_WIDTH - 1);
    // done marks the cycle whose edge folds in the final multiplier bit
    assign done    = r_busy && (r_cnt == w_last);
    assign product = r_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_dbl    <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{SIG_WIDTH{1'b0}}, mant_a};
            r_mplier <= mant_b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_dbl    <= dbl_sel;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_seq.sv
`default_nettype none
// ============================================================================
// Module : fp_mul_seq
// Brief  : Iterative double/single FP multiplier with valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module fp_mul_seq
    import fp_mul_seq_pkg::*;
(
    input  wire logic   in_clk,
    input  wire logic   in_rst_n,
    fp_mul_seq_if.slave bus
);

    logic [1:0]                   r_state;
    logic                         r_sign;
    logic                         r_dbl;
    logic [1:0]                   r_kind;
    logic signed [EXPC_WIDTH-1:0] r_exp;

    logic                         w_accept;
    logic                         w_dbl;
    logic [EXP_WIDTH-1:0]         w_ea;
    logic [EXP_WIDTH-1:0]         w_eb;
    logic                         w_any_ones;
    logic                         w_any_zero;
    logic                         w_sign;
    logic signed [EXPC_WIDTH-1:0] w_bias;
    logic signed [EXPC_WIDTH-1:0] w_emax_in;
    logic signed [EXPC_WIDTH-1:0] w_exp;
    logic [1:0]                   w_kind;
    logic [SIG_WIDTH-1:0]         w_mant_a;
    logic [SIG_WIDTH-1:0]         w_mant_b;
    logic                         w_start;
    logic [PROD_WIDTH-1:0]        w_prod;
    logic                         w_done;

    logic                         w_top;
    logic [MANT_WIDTH-1:0]        w_frac_dbl;
    logic [SGL_MANT_WIDTH-1:0]    w_frac_sgl;
    logic signed [EXPC_WIDTH-1:0] w_exp_n;
    logic signed [EXPC_WIDTH-1:0] w_emax_r;
    logic [1:0]                   w_kind_f;
    logic [DATA_WIDTH-1:0]        w_packed;
    logic                         w_unused_bits;

    assign bus.out_ready = (r_state == S_IDLE);
    assign w_accept      = bus.in_valid && (r_state == S_IDLE);

    // Operand unpack; single-precision fields live in the low word only
    assign w_dbl = bus.in_fmt;
    assign w_ea  = w_dbl ? bus.in_numA[62:52] : {3'b000, bus.in_numA[30:23]};
    assign w_eb  = w_dbl ? bus.in_numB[62:52] : {3'b000, bus.in_numB[30:23]};
    assign w_any_ones = w_dbl ? ((bus.in_numA[62:52] == C_EXP_ONES_DBL) || (bus.in_numB[62:52] == C_EXP_ONES_DBL))
                              : ((bus.in_numA[30:23] == C_EXP_ONES_SGL) || (bus.in_numB[30:23] == C_EXP_ONES_SGL));
    assign w_any_zero = (w_ea == '0) || (w_eb == '0);
    assign w_sign     = w_dbl ? (bus.in_numA[63] ^ bus.in_numB[63]) : (bus.in_numA[31] ^ bus.in_numB[31]);
    assign w_bias     = w_dbl ? C_BIAS_DBL : C_BIAS_SGL;
    assign w_emax_in  = w_dbl ? C_EMAX_DBL : C_EMAX_SGL;
    assign w_exp      = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - w_bias;

    assign w_mant_a = w_dbl ? {1'b1, bus.in_numA[MANT_WIDTH-1:0]}
                            : {{(SIG_WIDTH-SGL_SIG_WIDTH){1'b0}}, 1'b1, bus.in_numA[SGL_MANT_WIDTH-1:0]};
    assign w_mant_b = w_dbl ? {1'b1, bus.in_numB[MANT_WIDTH-1:0]}
                            : {{(SIG_WIDTH-SGL_SIG_WIDTH){1'b0}}, 1'b1, bus.in_numB[SGL_MANT_WIDTH-1:0]};

    always_comb begin
        w_kind = K_NORMAL;
        if (w_any_ones) begin
            w_kind = K_NAN;
        end else if (w_any_zero) begin
            w_kind = K_ZERO;
        end else if (w_exp >= w_emax_in) begin
            w_kind = K_INF;
        end else if (w_exp[EXPC_WIDTH-1] || (w_exp == '0)) begin
            w_kind = K_ZERO;
        end
    end

    assign w_start = w_accept && (w_kind == K_NORMAL);

    fp_mul_seq_mant u_mant (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .start   (w_start),
        .dbl_sel (w_dbl),
        .mant_a  (w_mant_a),
        .mant_b  (w_mant_b),
        .product (w_prod),
        .done    (w_done)
    );

    // Normalise by at most one place and truncate
    assign w_top      = r_dbl ? w_prod[PROD_WIDTH-1] : w_prod[2*SGL_SIG_WIDTH-1];
    assign w_frac_dbl = w_top ? w_prod[104:53] : w_prod[103:52];
    assign w_frac_sgl = w_top ? w_prod[46:24]  : w_prod[45:23];
    assign w_exp_n    = r_exp + $signed({{(EXPC_WIDTH-1){1'b0}}, w_top});
    assign w_emax_r   = r_dbl ? C_EMAX_DBL : C_EMAX_SGL;
    assign w_kind_f   = ((r_kind == K_NORMAL) && (w_exp_n >= w_emax_r)) ? K_INF : r_kind;
    assign w_unused_bits = ^w_prod[22:0];

    always_comb begin
        w_packed = '0;
        case (w_kind_f)
            K_NAN:  w_packed = r_dbl ? C_QNAN_DBL : C_QNAN_SGL;
            K_ZERO: w_packed = r_dbl ? {r_sign, 63'd0} : {C_BOX, r_sign, 31'd0};
            K_INF:  w_packed = r_dbl ? {r_sign, C_EXP_ONES_DBL, {MANT_WIDTH{1'b0}}}
                                     : {C_BOX, r_sign, C_EXP_ONES_SGL, {SGL_MANT_WIDTH{1'b0}}};
            default: w_packed = r_dbl ? {r_sign, w_exp_n[EXP_WIDTH-1:0], w_frac_dbl}
                                      : {C_BOX, r_sign, w_exp_n[SGL_EXP_WIDTH-1:0], w_frac_sgl};
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state        <= S_IDLE;
            r_sign         <= 1'b0;
            r_dbl          <= 1'b0;
            r_kind         <= K_NORMAL;
            r_exp          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign  <= w_sign;
                        r_dbl   <= w_dbl;
                        r_kind  <= w_kind;
                        r_exp   <= w_exp;
                        r_state <= (w_kind == K_NORMAL) ? S_MULT : S_NORM;
                    end
                end
                S_MULT: begin
                    if (w_done) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    bus.out_result <= w_packed;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle raises valid; the result then holds until taken
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                    end else if (bus.in_ready) begin
                        bus.out_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_mul_seq
// Brief  : Directed plus randomised self-checking bench for fp_mul_seq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp_mul_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    fp_mul_seq_if bus ();

    fp_mul_seq dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic s, input int e, input logic [63:0] frac, input logic fmt);
        logic [10:0] ed;
        logic [7:0]  es;
        ed = 11'(e);
        es = 8'(e);
        return fmt ? {s, ed, frac[51:0]} : {32'hFFFF_FFFF, s, es, frac[22:0]};
    endfunction

    // Reference: exact integer product of the significands, then IEEE-style field rules
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic fmt, output int lat);
        int n, bias, emax, ea, eb, e;
        logic s;
        logic [127:0] ma, mb, p;
        logic [63:0] frac;
        if (fmt) begin
            n = 53; bias = 1023; emax = 2047;
            ea = int'(a[62:52]); eb = int'(b[62:52]);
            s  = a[63] ^ b[63];
            ma = 128'(a[51:0]) | (128'd1 << 52);
            mb = 128'(b[51:0]) | (128'd1 << 52);
        end else begin
            n = 24; bias = 127; emax = 255;
            ea = int'(a[30:23]); eb = int'(b[30:23]);
            s  = a[31] ^ b[31];
            ma = 128'(a[22:0]) | (128'd1 << 23);
            mb = 128'(b[22:0]) | (128'd1 << 23);
        end
        lat = 2;
        if (ea == emax || eb == emax) return fmt ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
        if (ea == 0 || eb == 0) return pack(s, 0, 64'd0, fmt);
        e = ea + eb - bias;
        if (e >= emax) return pack(s, emax, 64'd0, fmt);
        if (e <= 0) return pack(s, 0, 64'd0, fmt);
        lat = n + 2;
        p = ma * mb;
        if (p[2*n-1]) begin
            frac = 64'(p >> n);
            e++;
        end else begin
            frac = 64'(p >> (n - 1));
        end
        if (e >= emax) return pack(s, emax, 64'd0, fmt);
        return pack(s, e, frac, fmt);
    endfunction

    function automatic logic [63:0] rand_op(input logic fmt);
        logic [63:0] m;
        logic [31:0] hi;
        int e;
        m  = {$urandom, $urandom};
        hi = $urandom;
        if (fmt) begin
            e = ($urandom % 8 == 0) ? int'($urandom_range(0, 2047)) : 1023 + int'($urandom_range(0, 300)) - 150;
            return {m[63], 11'(e), m[51:0]};
        end
        e = ($urandom % 8 == 0) ? int'($urandom_range(0, 255)) : 127 + int'($urandom_range(0, 80)) - 40;
        return {hi, m[63], 8'(e), m[22:0]};
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic fmt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.out_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.in_numA  = a;
        bus.in_numB  = b;
        bus.in_fmt   = fmt;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [63:0] res, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.out_result;
    endtask

    task automatic take();
        @(negedge clk);
        bus.in_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_ready = 1'b0;
    endtask

    task automatic run_directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                                input logic fmt, input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] res;
        int lat;
        send(a, b, fmt);
        wait_result(res, lat);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        take();
        check({tag, "_released"}, {62'd0, bus.out_valid, bus.out_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] a, b, exp_res, res, held;
        logic fmt;
        int exp_lat, lat;

        bus.in_valid = 1'b0;
        bus.in_ready = 1'b0;
        bus.in_numA  = '0;
        bus.in_numB  = '0;
        bus.in_fmt   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid",  64'(bus.out_valid),  64'd0);
        check("reset_ready",  64'(bus.out_ready),  64'd1);
        check("reset_result", bus.out_result,      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_directed("dbl_2x3",   64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1, 64'h4018_0000_0000_0000, 55);
        run_directed("sgl_15x15", 64'hFFFF_FFFF_3FC0_0000, 64'hFFFF_FFFF_3FC0_0000, 1'b0, 64'hFFFF_FFFF_4010_0000, 26);
        run_directed("dbl_negz",  64'h8000_0000_0000_0000, 64'h4014_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 2);
        run_directed("dbl_ovf",   64'h7FE0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 64'h7FF0_0000_0000_0000, 2);
        run_directed("dbl_nan",   64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 64'h7FF8_0000_0000_0000, 2);
        run_directed("sgl_unf",   64'hFFFF_FFFF_0080_0000, 64'hFFFF_FFFF_0080_0000, 1'b0, 64'hFFFF_FFFF_0000_0000, 2);

        // Held result under back-pressure; extra requests must be ignored
        send(64'hFFFF_FFFF_3FC0_0000, 64'hFFFF_FFFF_3FC0_0000, 1'b0);
        wait_result(held, lat);
        check("stall_first", held, 64'hFFFF_FFFF_4010_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_numA  = {$urandom, $urandom};
            bus.in_fmt   = 1'(i);
            @(posedge clk);
            #1;
            check("stall_result", bus.out_result, held);
            check("stall_flags", {62'd0, bus.out_valid, bus.out_ready}, 64'd2);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        take();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_no_extra", {62'd0, bus.out_valid, bus.out_ready}, 64'd1);
        end

        // Asynchronous reset in the middle of the multiply loop
        send(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flags",  {62'd0, bus.out_valid, bus.out_ready}, 64'd1);
        check("midrst_result", bus.out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_directed("post_rst", 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1, 64'h4018_0000_0000_0000, 55);

        for (int i = 0; i < 40; i++) begin
            fmt     = 1'($urandom);
            a       = rand_op(fmt);
            b       = rand_op(fmt);
            exp_res = ref_mul(a, b, fmt, exp_lat);
            send(a, b, fmt);
            wait_result(res, lat);
            check("rand_result", res, exp_res);
            check("rand_latency", 64'(lat), 64'(exp_lat));
            take();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
